// File: rtl/reg_snapshot_tracker_if.sv
// Writeback, vsync and freeze inputs plus snapshot/highlight outputs of reg_snapshot_tracker.
// master = writeback/display side, slave = the tracker itself.
interface reg_snapshot_tracker_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        vsync_in;
  logic        freeze;
  logic [31:0] regs_demo [0:31];
  logic [31:0] changed_mask;
  logic        frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, vsync_in, freeze,
    input  regs_demo, changed_mask, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, vsync_in, freeze,
    output regs_demo, changed_mask, frame_tick
  );
endinterface

// File: rtl/reg_snapshot_tracker.sv
// Shadow register file with frame-stable snapshot and per-register change highlight; REG_TRACK_ANY_WRITE_EN highlights same-value writes.
// Latency: tick 3 cycles after vsync edge, snapshot 1 cycle after tick, mask 1 cycle later.
// Backpressure: none; every write is accepted, freeze only defers snapshot and counter updates.
module reg_snapshot_tracker #(
  parameter int HOLD_FRAMES      = 60,
  parameter int CNT_W            = 6,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input logic                   clock,
  input logic                   reset_n,
  reg_snapshot_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      r_shadow [0:31];
  logic [31:0]      r_demo   [0:31];
  logic [CNT_W-1:0] r_cnt    [0:31];
  logic [31:0]      r_pending;
  logic [31:0]      r_mask;
  logic             r_tick;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_vs_prev;

  logic             w_wr_acc;
  logic             w_set;
  logic             w_update;
  logic             w_edge;
  logic [31:0]      w_set_vec;
  logic [31:0]      w_mask;

  always_comb begin
    w_wr_acc = bus.wr_en && (bus.wr_addr != 5'd0);
`ifdef REG_TRACK_ANY_WRITE_EN
    w_set    = w_wr_acc;
`else
    // Compared against the shadow before this cycle's write lands.
    w_set    = w_wr_acc && (bus.wr_data != r_shadow[bus.wr_addr]);
`endif
    w_set_vec = w_set ? (32'd1 << bus.wr_addr) : 32'd0;
    w_update  = r_tick && !bus.freeze;
    w_edge    = VSYNC_ACTIVE_LOW ? (r_vs_prev && !r_sync2) : (!r_vs_prev && r_sync2);
    w_mask    = 32'd0;
    for (int i = 1; i < 32; i++) begin
      w_mask[i] = |r_cnt[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_sync1   <= bus.vsync_in;
      r_sync2   <= r_sync1;
      r_vs_prev <= r_sync2;
      r_tick    <= w_edge;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_shadow[i] <= 32'd0;
        r_demo[i]   <= 32'd0;
        r_cnt[i]    <= '0;
      end
      r_pending <= 32'd0;
      r_mask    <= 32'd0;
    end else begin
      if (w_wr_acc) begin
        r_shadow[bus.wr_addr] <= bus.wr_data;
      end
      // A write landing on the tick keeps its pending bit for the next boundary.
      r_pending <= (w_update ? 32'd0 : r_pending) | w_set_vec;
      if (w_update) begin
        for (int i = 0; i < 32; i++) begin
          r_demo[i] <= r_shadow[i];
          if (r_pending[i]) begin
            r_cnt[i] <= HOLD_VAL;
          end else if (r_cnt[i] != '0) begin
            r_cnt[i] <= r_cnt[i] - CNT_ONE;
          end
        end
      end
      r_mask <= w_mask;
    end
  end

  assign bus.regs_demo    = r_demo;
  assign bus.changed_mask = r_mask;
  assign bus.frame_tick   = r_tick;

endmodule

// File: tb/tb_reg_snapshot_tracker.sv
// Directed bench for reg_snapshot_tracker: frame timing, snapshot latency, highlight hold, freeze and reset.
module tb_reg_snapshot_tracker;
  logic clock = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_demo [0:31];

  reg_snapshot_tracker_if bus();

  reg_snapshot_tracker #(
    .HOLD_FRAMES(60),
    .CNT_W(6),
    .VSYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, required finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clock);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  // Drops vsync and returns in the cycle frame_tick is high.
  task automatic frame_to_tick();
    bit seen;
    seen = 1'b0;
    bus.vsync_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (bus.frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL frame_tick_timeout: frame_tick=0 for 10 cycles, required 1");
    end
  endtask

  task automatic frame();
    frame_to_tick();
    cyc(1);
    bus.vsync_in = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset();
    bit bad;
    int extra;
    reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
    bus.vsync_in = 1'b1; bus.freeze = 1'b0;
    for (int i = 0; i < 32; i++) exp_demo[i] = 32'd0;
    cyc(3);
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (bus.regs_demo[i] !== 32'd0) bad = 1'b1;
    n_vec++;
    if (bad || bus.changed_mask !== 32'd0 || bus.frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: mask=%h tick=%b demo_nonzero=%b, required 0 0 0", bus.changed_mask, bus.frame_tick, bad);
    end
    reset_n = 1'b1;
    cyc(4);
    for (int f = 0; f < 3; f++) begin
      bus.vsync_in = 1'b0;
      cyc(2);
      n_vec++;
      if (bus.frame_tick !== 1'b0) begin
        n_err++;
        $display("FAIL tick_early f%0d: frame_tick=%b 2 cycles after edge, required 0", f, bus.frame_tick);
      end
      cyc(1);
      n_vec++;
      if (bus.frame_tick !== 1'b1) begin
        n_err++;
        $display("FAIL tick_at_3 f%0d: frame_tick=%b 3 cycles after edge, required 1", f, bus.frame_tick);
      end
      cyc(1);
      n_vec++;
      if (bus.frame_tick !== 1'b0) begin
        n_err++;
        $display("FAIL tick_width f%0d: frame_tick=%b, required 0", f, bus.frame_tick);
      end
      bus.vsync_in = 1'b1;
      extra = 0;
      for (int k = 0; k < 5; k++) begin
        cyc(1);
        if (bus.frame_tick === 1'b1) extra++;
      end
      bad = 1'b0;
      for (int i = 0; i < 32; i++) if (bus.regs_demo[i] !== 32'd0) bad = 1'b1;
      n_vec++;
      if (extra != 0 || bad || bus.changed_mask !== 32'd0) begin
        n_err++;
        $display("FAIL idle_frame f%0d: rising_ticks=%0d mask=%h demo_nonzero=%b, required 0 0 0", f, extra, bus.changed_mask, bad);
      end
    end
  endtask

  task automatic test_write_x5();
    int hi;
    wr(5'd5, 32'hDEADBEEF);
    exp_demo[5] = 32'hDEADBEEF;
    frame_to_tick();
    n_vec++;
    if (bus.regs_demo[5] !== 32'd0) begin
      n_err++;
      $display("FAIL x5_before_tick: regs_demo[5]=%h, required 00000000", bus.regs_demo[5]);
    end
    cyc(1);
    n_vec++;
    if (bus.regs_demo[5] !== 32'hDEADBEEF || bus.changed_mask[5] !== 1'b0) begin
      n_err++;
      $display("FAIL x5_after_tick: regs_demo[5]=%h mask5=%b, required deadbeef 0", bus.regs_demo[5], bus.changed_mask[5]);
    end
    cyc(1);
    n_vec++;
    if (bus.changed_mask[5] !== 1'b1) begin
      n_err++;
      $display("FAIL x5_mask_rise: mask5=%b, required 1", bus.changed_mask[5]);
    end
    bus.vsync_in = 1'b1;
    cyc(3);
    hi = 1;
    for (int k = 0; k < 59; k++) begin
      frame();
      if (bus.changed_mask[5] === 1'b1) hi++;
    end
    frame();
    n_vec++;
    if (hi != 60 || bus.changed_mask[5] !== 1'b0) begin
      n_err++;
      $display("FAIL x5_hold: high_frames=%0d final_mask5=%b, required 60 0", hi, bus.changed_mask[5]);
    end
  endtask

  task automatic test_write_x0();
    bit bad;
    wr(5'd0, 32'h12345678);
    frame();
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (bus.regs_demo[i] !== exp_demo[i]) bad = 1'b1;
    n_vec++;
    if (bad || bus.regs_demo[0] !== 32'd0) begin
      n_err++;
      $display("FAIL x0_ignored: regs_demo[0]=%h other_diff=%b, required 00000000 0", bus.regs_demo[0], bad);
    end
    n_vec++;
    if (bus.changed_mask !== 32'd0) begin
      n_err++;
      $display("FAIL x0_mask: changed_mask=%h, required 00000000", bus.changed_mask);
    end
  endtask

  task automatic test_write_on_tick();
    frame_to_tick();
    wr(5'd7, 32'h1);
    n_vec++;
    if (bus.regs_demo[7] !== 32'd0) begin
      n_err++;
      $display("FAIL x7_same_tick: regs_demo[7]=%h, required 00000000", bus.regs_demo[7]);
    end
    bus.vsync_in = 1'b1;
    cyc(4);
    n_vec++;
    if (bus.changed_mask[7] !== 1'b0) begin
      n_err++;
      $display("FAIL x7_mask_early: mask7=%b, required 0", bus.changed_mask[7]);
    end
    frame();
    exp_demo[7] = 32'h1;
    n_vec++;
    if (bus.regs_demo[7] !== 32'h1 || bus.changed_mask[7] !== 1'b1) begin
      n_err++;
      $display("FAIL x7_next_tick: regs_demo[7]=%h mask7=%b, required 00000001 1", bus.regs_demo[7], bus.changed_mask[7]);
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd12, 32'h5);
    wr(5'd12, 32'h0);
    frame();
    n_vec++;
    if (bus.regs_demo[12] !== 32'h0 || bus.changed_mask[12] !== 1'b1) begin
      n_err++;
      $display("FAIL x12_last_value: regs_demo[12]=%h mask12=%b, required 00000000 1", bus.regs_demo[12], bus.changed_mask[12]);
    end
  endtask

  task automatic test_same_value();
    int n;
    int want;
`ifdef REG_TRACK_ANY_WRITE_EN
    want = 61;
`else
    want = 59;
`endif
    wr(5'd3, 32'hA);
    exp_demo[3] = 32'hA;
    frame();
    n_vec++;
    if (bus.regs_demo[3] !== 32'hA || bus.changed_mask[3] !== 1'b1) begin
      n_err++;
      $display("FAIL x3_first: regs_demo[3]=%h mask3=%b, required 0000000a 1", bus.regs_demo[3], bus.changed_mask[3]);
    end
    frame();
    wr(5'd3, 32'hA);
    n = 0;
    for (int k = 0; k < 70; k++) begin
      frame();
      n++;
      if (bus.changed_mask[3] !== 1'b1) break;
    end
    n_vec++;
    if (n != want) begin
      n_err++;
      $display("FAIL x3_same_value: frames_to_clear=%0d, required %0d", n, want);
    end
  endtask

  task automatic test_freeze();
    int n;
    wr(5'd11, 32'h22);
    frame();
    frame();
    bus.freeze = 1'b1;
    wr(5'd9, 32'h55);
    for (int f = 0; f < 5; f++) begin
      frame();
      n_vec++;
      if (bus.regs_demo[9] !== 32'd0 || bus.regs_demo[11] !== 32'h22 || bus.changed_mask[9] !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_hold f%0d: regs_demo[9]=%h regs_demo[11]=%h mask9=%b, required 00000000 00000022 0",
                 f, bus.regs_demo[9], bus.regs_demo[11], bus.changed_mask[9]);
      end
    end
    bus.freeze = 1'b0;
    frame();
    n_vec++;
    if (bus.regs_demo[9] !== 32'h55 || bus.changed_mask[9] !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_release: regs_demo[9]=%h mask9=%b, required 00000055 1", bus.regs_demo[9], bus.changed_mask[9]);
    end
    n = 1;
    while (bus.changed_mask[11] === 1'b1 && n < 70) begin
      frame();
      n++;
    end
    n_vec++;
    if (n != 59) begin
      n_err++;
      $display("FAIL freeze_counter_held: x11 frames_to_clear=%0d, required 59", n);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd13; bus.wr_data = 32'hCAFEF00D;
    bus.vsync_in = 1'b0;
    #1;
    reset_n = 1'b0;
    #2;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (bus.regs_demo[i] !== 32'd0) bad = 1'b1;
    n_vec++;
    if (bad || bus.changed_mask !== 32'd0 || bus.frame_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_immediate: mask=%h tick=%b demo_nonzero=%b, required 0 0 0", bus.changed_mask, bus.frame_tick, bad);
    end
    bus.wr_en = 1'b0;
    bus.vsync_in = 1'b1;
    cyc(2);
    reset_n = 1'b1;
    cyc(4);
    frame();
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (bus.regs_demo[i] !== 32'd0) bad = 1'b1;
    n_vec++;
    if (bad || bus.changed_mask !== 32'd0) begin
      n_err++;
      $display("FAIL reset_no_survivor: mask=%h demo_nonzero=%b, required 0 0", bus.changed_mask, bad);
    end
  endtask

  initial begin
    test_reset();
    test_write_x5();
    test_write_x0();
    test_write_on_tick();
    test_back_to_back();
    test_same_value();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_snapshot_tracker.md
Name: reg_snapshot_tracker

Overview:
- Sits between the RISC-V core writeback port and the VGA register debug display.
- Keeps a shadow copy of the 32 architectural registers.
- Presents a tear-free snapshot, regs_demo[0:31], that updates only at frame boundaries.
- Presents changed_mask[31:0]; each bit stays high for a programmable number of frames after that register changes.

Parameters:
- HOLD_FRAMES, 60: number of frame boundaries a highlight persists after a change; legal range 1 to 2^CNT_W-1.
- CNT_W, 6: width of each per-register hold counter.
- VSYNC_ACTIVE_LOW, 1: 1 = the boundary is the falling edge of vsync_in; 0 = the boundary is the rising edge.

Ports:
- clock  in  1  core clock; all state is in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register-file write strobe from writeback.
- wr_addr  in  5  destination register index.
- wr_data  in  32  write data.
- vsync_in  in  1  VGA vsync; asynchronous to clock.
- freeze  in  1  while high: snapshot held, counters held, pending writes accumulate.
- regs_demo  out  32x[0:31]  frame-stable register snapshot.
- changed_mask  out  32  bit i = hold counter i is nonzero.
- frame_tick  out  1  one-cycle pulse at each detected frame boundary.

Behaviour:
- Reset (async assert, sync release): everything clears to 0, specifically:
  - shadow file, regs_demo, pending mask, hold counters, changed_mask, frame_tick;
  - both vsync synchroniser flops and the edge-detect flop.
- Shadow write:
  - On a rising clock with wr_en=1 and wr_addr!=0, shadow[wr_addr] <= wr_data.
  - wr_addr=0 is ignored entirely; shadow[0] and regs_demo[0] stay 0.
- Pending:
  - pending[wr_addr] is set on any accepted write where wr_data != shadow[wr_addr], compared before the update.
  - A write of an equal value does not set pending.
- Frame boundary detection:
  - vsync_in passes through a 2-flop synchroniser, then an edge detector with polarity set by VSYNC_ACTIVE_LOW.
  - The chosen edge produces frame_tick=1 for exactly one cycle, 3 clock cycles after the edge appears on vsync_in.
- On frame_tick with freeze=0, all in the same cycle:
  - regs_demo[i] <= shadow[i] for every i.
  - If pending[i]: counter[i] <= HOLD_FRAMES.
  - Otherwise, if counter[i] != 0: counter[i] <= counter[i] - 1; counters saturate at 0 and never wrap.
  - pending <= 0.
- Write coinciding with frame_tick:
  - The snapshot takes the pre-write shadow value.
  - That write's pending bit survives the clear (set wins over clear).
  - The value and its highlight appear at the next boundary.
- On frame_tick with freeze=1:
  - No snapshot copy, no counter change, pending retained.
  - frame_tick output still pulses.
- changed_mask:
  - Registered as the OR-reduce of each counter, updated the cycle after the counter changes.
  - Bit 0 is always 0.
- Latency:
  - A write in cycle N is visible in regs_demo one cycle after the first frame_tick occurring after cycle N.
  - changed_mask follows one cycle later still.
- Multiple writes to one register within a frame: the snapshot shows the last value. Highlight is set if any of those writes differed from the shadow at its time.
- Freeze release: the next boundary copies everything accumulated during the freeze.
- reset_n asserted mid-frame or mid-write: immediate clear; no partial snapshot survives.

Optional Feature:
- Macro: REG_TRACK_ANY_WRITE_EN.
- Defined: every accepted write (wr_addr!=0) sets pending, including same-value writes, so a store of an identical value still highlights.
- Undefined: pending requires a value change, as specified above.
- Shadow and snapshot behaviour are identical in both builds.

Test Plan:
- Reset then idle 3 frames: regs_demo all 0, changed_mask=0, one frame_tick per vsync falling edge, tick 3 cycles after the edge.
- Write x5=0xDEADBEEF mid-frame: regs_demo[5] unchanged until the next frame_tick, then 0xDEADBEEF. changed_mask[5]=1 for exactly HOLD_FRAMES=60 ticks, then 0.
- Write x0=0x12345678: regs_demo[0] stays 0, changed_mask[0] stays 0, no other register affected.
- Write x7=0x1 in the same cycle as frame_tick:
  - At that tick, regs_demo[7] keeps its old value.
  - At the next tick it becomes 0x1 and mask[7] rises.
- Write x3=0xA, tick, then write x3=0xA again:
  - Without the macro, the second write causes no new highlight; counter keeps decrementing.
  - With REG_TRACK_ANY_WRITE_EN, counter[3] reloads to 60.
- freeze=1 for 5 ticks while writing x9=0x55: regs_demo[9] and all counters hold. On the first tick after freeze=0, regs_demo[9]=0x55 and mask[9]=1. Assert reset_n=0 mid-frame: all outputs 0 immediately.
